// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the pointer counter and its benches.
// Functions work on a fixed-width word; callers zero-extend narrower values.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/b2g_converter.sv
// Purely combinational binary-to-Gray converter.
module b2g_converter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_ptr_counter.sv
// Registered binary/Gray pointer counter for CDC pointer paths.
// Gray output comes straight from a flop so only one bit toggles per step.
module gray_ptr_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             inc,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap
);

  logic [WIDTH-1:0] bin_d,  bin_q;
  logic [WIDTH-1:0] gray_d, gray_q;
  logic             wrap_d, wrap_q;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_bin;
    end else if (inc) begin
      bin_d  = bin_q + WIDTH'(1);
      wrap_d = (bin_q == {WIDTH{1'b1}});
    end
  end

  // One converter on the next binary value feeds both the Gray flop and gray_next.
  b2g_converter #(.WIDTH(WIDTH)) u_b2g (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all three flops
  // sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin       = bin_q;
  assign gray      = gray_q;
  assign wrap      = wrap_q;
  // Same-domain full/empty logic only; never synchronise this combinational value.
  assign gray_next = gray_d;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Directed and model-checked bench for gray_ptr_counter at WIDTH=4.
module tb_gray_ptr_counter;
  import gray_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         load;
  logic [W-1:0] load_bin;
  logic         inc;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic [W-1:0] gray_next;
  logic         wrap;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] gn_s;
  logic [W-1:0] prev_gray;
  logic [W-1:0] bin_m;
  logic [W-1:0] nxt_m;
  logic         wrap_m;

  logic [W-1:0] walk [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  always #5 clk = ~clk;

  gray_ptr_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (load),
    .load_bin  (load_bin),
    .inc       (inc),
    .bin       (bin),
    .gray      (gray),
    .gray_next (gray_next),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] g4(input logic [W-1:0] b);
    word_t t;
    t = bin2gray(word_t'(b));
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] b4(input logic [W-1:0] g);
    word_t t;
    t = gray2bin(word_t'(g));
    return t[W-1:0];
  endfunction

  // Drive inputs mid-cycle, sample gray_next before the edge, then step past the edge.
  task automatic cycle(input logic c, input logic l, input logic [W-1:0] lb, input logic i);
    clr      = c;
    load     = l;
    load_bin = lb;
    inc      = i;
    #1;
    gn_s = gray_next;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_bin = '0;
    inc      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bin",  32'(bin),  0);
    check("rst_gray", 32'(gray), 0);
    check("rst_wrap", 32'(wrap), 0);
    inc = 1'b1;
    #1;
    check("rst_gray_next", 32'(gray_next), 1);
    rst = 1'b0;

    // Full 16-step walk through the Gray sequence with wrap on the last step.
    for (int i = 0; i < 16; i++) begin
      prev_gray = gray;
      cycle(1'b0, 1'b0, 4'h0, 1'b1);
      check("walk_gray_next", 32'(gn_s), 32'(walk[i]));
      check("walk_bin",  32'(bin),  32'((i + 1) % 16));
      check("walk_gray", 32'(gray), 32'(walk[i]));
      check("walk_wrap", 32'(wrap), (i == 15) ? 1 : 0);
      check("walk_one_bit", $countones(gray ^ prev_gray), 1);
    end

    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    check("idle_bin",  32'(bin),  0);
    check("idle_gray", 32'(gray), 0);
    check("idle_wrap", 32'(wrap), 0);

    cycle(1'b0, 1'b1, 4'hA, 1'b0);
    check("load_bin",  32'(bin),  'hA);
    check("load_gray", 32'(gray), 'hF);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    check("load_inc_bin",  32'(bin),  'hB);
    check("load_inc_gray", 32'(gray), 'hE);

    // clr beats load and inc at all-ones, and never raises wrap.
    cycle(1'b0, 1'b1, 4'hF, 1'b0);
    check("ones_gray", 32'(gray), 'h8);
    cycle(1'b1, 1'b1, 4'h5, 1'b1);
    check("clr_prio_gray_next", 32'(gn_s), 0);
    check("clr_prio_bin",  32'(bin),  0);
    check("clr_prio_gray", 32'(gray), 0);
    check("clr_prio_wrap", 32'(wrap), 0);

    // load beats inc at all-ones, and never raises wrap.
    cycle(1'b0, 1'b1, 4'hF, 1'b0);
    cycle(1'b0, 1'b1, 4'h7, 1'b1);
    check("load_prio_bin",  32'(bin),  'h7);
    check("load_prio_gray", 32'(gray), 'h4);
    check("load_prio_wrap", 32'(wrap), 0);

    // Asynchronous reset mid-count with inc held high.
    cycle(1'b0, 1'b1, 4'h9, 1'b0);
    check("pre_rst_bin",  32'(bin),  'h9);
    check("pre_rst_gray", 32'(gray), 'hD);
    load = 1'b0;
    inc  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bin",  32'(bin),  0);
    check("async_rst_gray", 32'(gray), 0);
    check("async_rst_wrap", 32'(wrap), 0);
    check("async_rst_gray_next", 32'(gray_next), 1);
    @(posedge clk);
    #1;
    check("held_rst_bin", 32'(bin), 0);
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_bin",  32'(bin),  32'(i));
      check("post_rst_gray", 32'(gray), (i == 1) ? 'h1 : (i == 2) ? 'h3 : 'h2);
    end

    // Random traffic against a reference model.
    bin_m = 4'h3;
    for (int n = 0; n < 2000; n++) begin
      logic         c;
      logic         l;
      logic         i;
      logic [W-1:0] lb;
      c  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 7) == 0);
      i  = ($urandom_range(0, 3) != 0);
      lb = W'($urandom_range(0, 15));
      if (c)      nxt_m = '0;
      else if (l) nxt_m = lb;
      else if (i) nxt_m = bin_m + W'(1);
      else        nxt_m = bin_m;
      wrap_m = i && !c && !l && (bin_m == 4'hF);
      cycle(c, l, lb, i);
      bin_m = nxt_m;
      check("rnd_gray_next", 32'(gn_s), 32'(g4(bin_m)));
      check("rnd_bin",  32'(bin),  32'(bin_m));
      check("rnd_gray", 32'(gray), 32'(g4(bin_m)));
      check("rnd_wrap", 32'(wrap), 32'(wrap_m));
      check("rnd_gray2bin", 32'(b4(gray)), 32'(bin_m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
